// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI master byte shift engine driven by divider edge pulses
module spi_shift_engine #(
   parameter int CS_SETUP  = 2,
   parameter int CS_HOLD   = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   input  logic       i_cpol,
   input  logic       i_cpha,
   input  logic       i_hold_cs,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   input  logic       i_div_ready,
   input  logic       i_div_clk,
   input  logic       i_div_rise,
   input  logic       i_div_fall,
   output logic       o_div_start_n,
   output logic       o_sclk,
   output logic       o_mosi,
   input  logic       i_miso,
   output logic       o_cs_n
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_START,
      ST_SHIFT,
      ST_HOLD
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] tx_sr;
   logic [7:0] rx_sr;
   logic [3:0] bit_cnt;
   logic       cpol_l;
   logic       cpha_l;
   logic       hold_l;
   logic       cs_n_q;
   logic       mosi_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;

   logic       accept;
   logic       setup_done;
   logic       hold_done;
   logic       byte_done;
   logic       edges_on;
   logic       sample_ev;
   logic       drive_ev;
   logic [7:0] tx_ord;

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = d[7-i];
      end
      return r;
   endfunction

   // Shift register always emits bit 7 first; LSB-first mode pre-reverses the byte.
   assign tx_ord     = MSB_FIRST ? i_tx_data : rev8(i_tx_data);

   assign o_tx_ready = (state == ST_IDLE) && !i_rst;
   assign accept     = i_tx_valid && o_tx_ready;
   assign setup_done = (wait_cnt == 8'(CS_SETUP - 1));
   assign hold_done  = (wait_cnt == 8'(CS_HOLD - 1));
   assign byte_done  = (state == ST_SHIFT) && (bit_cnt == 4'd8) && i_div_ready;

   // Edges are honoured from START too, so a divider that pulses in its first busy cycle is not missed.
   assign edges_on   = ((state == ST_START) || (state == ST_SHIFT)) && (bit_cnt < 4'd8);
   assign sample_ev  = edges_on && (cpha_l ? i_div_fall : i_div_rise);
   assign drive_ev   = edges_on && !sample_ev && (cpha_l ? i_div_rise : i_div_fall);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept)       state_nxt = ST_SETUP;
         ST_SETUP: if (setup_done)   state_nxt = ST_START;
         ST_START: if (!i_div_ready) state_nxt = ST_SHIFT;
         ST_SHIFT: if (byte_done)    state_nxt = ST_HOLD;
         ST_HOLD:  if (hold_done)    state_nxt = ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= 8'd0;
         tx_sr      <= 8'd0;
         rx_sr      <= 8'd0;
         bit_cnt    <= 4'd0;
         cpol_l     <= 1'b0;
         cpha_l     <= 1'b0;
         hold_l     <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         rx_valid_q <= 1'b0;

         if (state_nxt != state) begin
            wait_cnt <= 8'd0;
         end else if ((state == ST_SETUP) || (state == ST_HOLD)) begin
            wait_cnt <= wait_cnt + 8'd1;
         end

         if (accept) begin
            cpol_l  <= i_cpol;
            cpha_l  <= i_cpha;
            hold_l  <= i_hold_cs;
            cs_n_q  <= 1'b0;
            bit_cnt <= 4'd0;
            if (!i_cpha) begin
               mosi_q <= tx_ord[7];
               tx_sr  <= {tx_ord[6:0], 1'b0};
            end else begin
               tx_sr  <= tx_ord;
            end
         end

         if (sample_ev) begin
            rx_sr   <= {rx_sr[6:0], i_miso};
            bit_cnt <= bit_cnt + 4'd1;
         end

         if (drive_ev) begin
            mosi_q <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b0};
         end

         if (byte_done) begin
            rx_data_q  <= MSB_FIRST ? rx_sr : rev8(rx_sr);
            rx_valid_q <= 1'b1;
         end

         if ((state == ST_HOLD) && hold_done && !hold_l) begin
            cs_n_q <= 1'b1;
         end
      end
   end

   assign o_div_start_n = (state != ST_START);
   assign o_sclk        = i_div_clk ^ cpol_l;
   assign o_mosi        = mosi_q;
   assign o_cs_n        = cs_n_q;
   assign o_rx_data     = rx_data_q;
   assign o_rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - directed scoreboard bench for spi_shift_engine (MSB-first and LSB-first instances)
module tb_spi_shift_engine;

   localparam int SETUP0 = 2;
   localparam int HOLD0  = 2;
   localparam int SETUP1 = 3;
   localparam int HOLD1  = 3;

   typedef struct {
      logic [7:0] rx;
      logic [7:0] mo;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [7:0]      tx_data;
   logic            cpol, cpha, hold_cs;
   logic [1:0]      tx_valid, tx_ready, rx_valid;
   logic [1:0][7:0] rx_data;
   logic [1:0]      div_ready, div_clk, div_rise, div_fall, start_n;
   logic [1:0]      sclk, mosi, miso, cs_n;
   logic            loop_en, tie_val;

   assign miso = loop_en ? mosi : {2{tie_val}};

   spi_shift_engine #(.CS_SETUP(SETUP0), .CS_HOLD(HOLD0), .MSB_FIRST(1'b1)) u_msb (
      .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data), .i_tx_valid(tx_valid[0]),
      .o_tx_ready(tx_ready[0]), .i_cpol(cpol), .i_cpha(cpha), .i_hold_cs(hold_cs),
      .o_rx_data(rx_data[0]), .o_rx_valid(rx_valid[0]), .i_div_ready(div_ready[0]),
      .i_div_clk(div_clk[0]), .i_div_rise(div_rise[0]), .i_div_fall(div_fall[0]),
      .o_div_start_n(start_n[0]), .o_sclk(sclk[0]), .o_mosi(mosi[0]), .i_miso(miso[0]),
      .o_cs_n(cs_n[0])
   );

   spi_shift_engine #(.CS_SETUP(SETUP1), .CS_HOLD(HOLD1), .MSB_FIRST(1'b0)) u_lsb (
      .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data), .i_tx_valid(tx_valid[1]),
      .o_tx_ready(tx_ready[1]), .i_cpol(cpol), .i_cpha(cpha), .i_hold_cs(hold_cs),
      .o_rx_data(rx_data[1]), .o_rx_valid(rx_valid[1]), .i_div_ready(div_ready[1]),
      .i_div_clk(div_clk[1]), .i_div_rise(div_rise[1]), .i_div_fall(div_fall[1]),
      .o_div_start_n(start_n[1]), .o_sclk(sclk[1]), .o_mosi(mosi[1]), .i_miso(miso[1]),
      .o_cs_n(cs_n[1])
   );

   int         total = 0;
   int         bad   = 0;
   exp_t       q0[$];
   exp_t       q1[$];
   int         cyc = 0;
   int         mcnt[2], rxv_cnt[2], rxv_cyc[2], acc_cnt[2];
   logic [7:0] mbits[2];
   logic [1:0] mcpha;
   logic [1:0] cs_prev, ready_prev;
   logic       rst_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Divider model: 8 slow periods, 4 clk cycles each, pulses one cycle ahead of the level change.
   int         ph[2];
   bit         busy[2];
   logic [1:0] sn;
   initial begin
      div_ready = '1; div_rise = '0; div_fall = '0; div_clk = '0;
      busy[0] = 0; busy[1] = 0; ph[0] = 0; ph[1] = 0; sn = '1;
      forever begin
         @(negedge clk);
         sn = start_n;
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               busy[k] = 0; div_ready[k] = 1'b1; div_rise[k] = 1'b0;
               div_fall[k] = 1'b0; div_clk[k] = 1'b0;
            end else if (!busy[k]) begin
               if (!sn[k] && div_ready[k]) begin
                  busy[k] = 1; div_ready[k] = 1'b0; ph[k] = 0;
               end
            end else begin
               if (div_rise[k]) div_clk[k] = 1'b1;
               if (div_fall[k]) div_clk[k] = 1'b0;
               div_rise[k] = 1'b0;
               div_fall[k] = 1'b0;
               if (ph[k] < 32) begin
                  if (ph[k] % 4 == 0) div_rise[k] = 1'b1;
                  else if (ph[k] % 4 == 2) div_fall[k] = 1'b1;
                  ph[k]++;
               end else begin
                  busy[k] = 0;
                  div_ready[k] = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: collects MOSI at each slave sample point and pops the scoreboard on o_rx_valid.
   initial begin
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; rxv_cnt[k] = 0; rxv_cyc[k] = 0; acc_cnt[k] = 0; mbits[k] = 8'd0;
      end
      cs_prev = '1; ready_prev = '0; rst_prev = 1'b1;
      forever begin
         exp_t e;
         @(posedge clk);
         #2;
         cyc++;
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               mcnt[k] = 0;
               mbits[k] = 8'd0;
            end else begin
               if (mcnt[k] < 8 && (mcpha[k] ? div_fall[k] : div_rise[k])) begin
                  mbits[k] = {mbits[k][6:0], mosi[k]};
                  mcnt[k]++;
               end
               if (div_rise[k] || div_fall[k])
                  check($sformatf("cs_low_on_edge%0d", k), 32'(cs_n[k]), 32'd0);
               if (rx_valid[k]) begin
                  check($sformatf("ready_low_busy%0d", k), 32'(tx_ready[k]), 32'd0);
                  if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                     check($sformatf("rx_valid_unexpected%0d", k), 32'd1, 32'd0);
                  end else begin
                     e = (k == 0) ? q0.pop_front() : q1.pop_front();
                     check($sformatf("rx_data%0d", k), 32'(rx_data[k]), 32'(e.rx));
                     check($sformatf("mosi_seq%0d", k), 32'(mbits[k]), 32'(e.mo));
                     check($sformatf("bit_count%0d", k), 32'(mcnt[k]), 32'd8);
                  end
                  mcnt[k] = 0;
                  rxv_cnt[k]++;
                  rxv_cyc[k] = cyc;
               end
               if (cs_n[k] && !cs_prev[k] && !rst_prev)
                  check($sformatf("cs_hold_time%0d", k), 32'(cyc - rxv_cyc[k]),
                        32'(k == 0 ? HOLD0 : HOLD1));
               if (ready_prev[k] && !tx_ready[k]) acc_cnt[k]++;
            end
         end
         cs_prev = cs_n;
         ready_prev = tx_ready;
         rst_prev = rst;
      end
   end

   task automatic send(input int k, input logic [7:0] d, input logic pol, input logic pha,
                       input logic hold, input bit push, input logic [7:0] erx, input logic [7:0] emo);
      int   n;
      exp_t e;
      n = 0;
      while (tx_ready[k] !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(n < 2000), 32'd1);
      tx_data = d; cpol = pol; cpha = pha; hold_cs = hold;
      mcpha[k] = pha;
      tx_valid[k] = 1'b1;
      if (push) begin
         e.rx = erx;
         e.mo = emo;
         if (k == 0) q0.push_back(e);
         else q1.push_back(e);
      end
      @(negedge clk);
      tx_valid[k] = 1'b0;
      check("cs_assert", 32'(cs_n[k]), 32'd0);
      check("ready_after_accept", 32'(tx_ready[k]), 32'd0);
      check("sclk_idle", 32'(sclk[k]), 32'(pol));
      n = 1;
      while (start_n[k] !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("start_latency", 32'(n), 32'(k == 0 ? SETUP0 + 1 : SETUP1 + 1));
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_ready[k] !== 1'b1 && n < 2000);
      check("idle_wait", 32'(n < 2000), 32'd1);
   endtask

   initial begin
      int n, r0, r1, a1;
      rst = 1'b1; tx_valid = '0; tx_data = 8'd0; cpol = 1'b0; cpha = 1'b0; hold_cs = 1'b0;
      loop_en = 1'b1; tie_val = 1'b0; mcpha = '0;
      repeat (3) @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_cs_n", 32'(cs_n), 32'h3);
      check("rst_start_n", 32'(start_n), 32'h3);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_sclk", 32'(sclk), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(tx_ready), 32'h3);

      send(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 8'hA5);
      wait_idle(0);
      check("cs_release_a5", 32'(cs_n[0]), 32'd1);

      loop_en = 1'b0; tie_val = 1'b1;
      send(0, 8'h3C, 1'b1, 1'b1, 1'b0, 1, 8'hFF, 8'h3C);
      wait_idle(0);
      check("sclk_idle_high_mode3", 32'(sclk[0]), 32'd1);
      loop_en = 1'b1; tie_val = 1'b0;

      send(1, 8'h01, 1'b0, 1'b1, 1'b0, 1, 8'h01, 8'h80);
      wait_idle(1);

      r0 = rxv_cnt[0];
      send(0, 8'h12, 1'b0, 1'b0, 1'b1, 1, 8'h12, 8'h12);
      wait_idle(0);
      check("cs_held_between", 32'(cs_n[0]), 32'd0);
      send(0, 8'h34, 1'b0, 1'b0, 1'b0, 1, 8'h34, 8'h34);
      wait_idle(0);
      check("two_rx_pulses", 32'(rxv_cnt[0] - r0), 32'd2);
      check("cs_release_34", 32'(cs_n[0]), 32'd1);

      r0 = rxv_cnt[0];
      send(0, 8'hC3, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h00);
      n = 0;
      while (mcnt[0] < 4 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("reach_bit4", 32'(n < 500), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cs_n", 32'(cs_n[0]), 32'd1);
      check("midrst_start_n", 32'(start_n[0]), 32'd1);
      check("midrst_rx_data", 32'(rx_data[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ready", 32'(tx_ready[0]), 32'd1);
      repeat (40) @(negedge clk);
      check("midrst_no_rx_valid", 32'(rxv_cnt[0] - r0), 32'd0);
      send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 8'h5A, 8'h5A);
      wait_idle(0);

      r1 = rxv_cnt[1];
      a1 = acc_cnt[1];
      tx_data = 8'h96; cpol = 1'b0; cpha = 1'b0; hold_cs = 1'b0; mcpha[1] = 1'b0;
      q1.push_back('{rx: 8'h96, mo: 8'h69});
      q1.push_back('{rx: 8'h96, mo: 8'h69});
      tx_valid[1] = 1'b1;
      n = 0;
      while ((rxv_cnt[1] - r1) < 2 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      tx_valid[1] = 1'b0;
      check("held_valid_wait", 32'(n < 3000), 32'd1);
      check("held_valid_accepts", 32'(acc_cnt[1] - a1), 32'd2);
      wait_idle(1);

      repeat (5) @(negedge clk);
      check("scoreboard_empty0", 32'(q0.size()), 32'd0);
      check("scoreboard_empty1", 32'(q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Byte-level SPI master data path; sits directly downstream of the SPI clock divider.
- Accepts a TX byte over a valid/ready handshake, drives chip select, and starts one 8-period divider burst.
- Uses the divider's edge pulses to shift MOSI and sample MISO, then returns the RX byte with a one-cycle valid strobe.
- Applies CPOL/CPHA mode mapping and bit-order selection.

Parameters:
- CS_SETUP, 2, i_clk cycles from CS assert to divider start (1..255)
- CS_HOLD, 2, i_clk cycles from last divider edge to CS release (1..255)
- MSB_FIRST, 1, 1 = shift bit 7 first; 0 = shift bit 0 first

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_tx_data  in  8  byte to transmit
- i_tx_valid  in  1  request; i_tx_data, i_cpol, i_cpha and i_hold_cs are captured when i_tx_valid & o_tx_ready
- o_tx_ready  out  1  engine idle, can accept a byte
- i_cpol  in  1  SPI clock polarity
- i_cpha  in  1  SPI clock phase
- i_hold_cs  in  1  keep CS asserted after this byte (multi-byte frame)
- o_rx_data  out  8  received byte, stable until the next capture
- o_rx_valid  out  1  one-cycle strobe, o_rx_data valid
- i_div_ready  in  1  divider idle
- i_div_clk  in  1  divider slow clock (idles 0)
- i_div_rise  in  1  divider pulse: slow clock goes 0->1 at the end of this cycle (leading edge)
- i_div_fall  in  1  divider pulse: slow clock goes 1->0 at the end of this cycle (trailing edge)
- o_div_start_n  out  1  active-low start request to the divider
- o_sclk  out  1  SPI clock = i_div_clk ^ cpol_latched
- o_mosi  out  1  SPI data out
- i_miso  in  1  SPI data in
- o_cs_n  out  1  SPI chip select, active low

Behaviour:
- Reset values:
  - o_tx_ready=0 during reset, 1 in the first cycle after reset.
  - o_rx_data=0, o_rx_valid=0, o_div_start_n=1, o_mosi=0, o_cs_n=1, o_sclk=0 (cpol_latched=0).
- States: IDLE, SETUP, START, SHIFT, HOLD.
- IDLE:
  - o_tx_ready=1.
  - On accept: latch the byte into the shift register and latch the mode bits.
  - Assert o_cs_n=0 (if not already low), then go to SETUP.
- SETUP:
  - Count CS_SETUP cycles.
  - If CPHA=0, drive o_mosi with the first bit on entry.
  - Then go to START.
- START:
  - Hold o_div_start_n=0 until i_div_ready=0 is seen, then release to 1 and go to SHIFT.
  - If the divider never leaves ready, the engine stays in START; there is no timeout.
- SHIFT, CPHA=0:
  - Sample i_miso into the RX shift register in each cycle where i_div_rise=1.
  - Drive the next TX bit on o_mosi in each cycle where i_div_fall=1, except after the 8th sample.
- SHIFT, CPHA=1:
  - Drive the next TX bit (the first bit on the first pulse) when i_div_rise=1.
  - Sample i_miso when i_div_fall=1.
- Bit counter:
  - 4 bits; increments on each sample; saturates at 8.
  - Extra edge pulses after the count reaches 8 are ignored.
- End of byte:
  - When the count is 8 and i_div_ready=1: load o_rx_data (bit-reversed if MSB_FIRST=0).
  - Pulse o_rx_valid on the next cycle, then enter HOLD.
- HOLD:
  - Count CS_HOLD cycles.
  - If the latched hold_cs=0: o_cs_n=1 and return to IDLE.
  - If the latched hold_cs=1: o_cs_n stays 0 and return to IDLE, so the next byte skips the CS assert edge but still runs SETUP.
- cpol_latched changes only on accept. A mode change with CS held is permitted, but the result is the user's responsibility.
- i_tx_valid while o_tx_ready=0 is ignored; no queuing.
- i_rst mid-transfer:
  - Next cycle: o_cs_n=1, o_div_start_n=1, state IDLE.
  - No o_rx_valid; o_rx_data cleared to 0.
- Simultaneous i_div_rise and i_div_fall: must not occur. If it does, the sample takes priority and no shift happens that cycle.
- Latency:
  - Accept to first divider start: CS_SETUP+1 cycles.
  - Last sample to o_rx_valid: ≤2 cycles after i_div_ready returns.

Test Plan:
- Mode 0, MSB_FIRST=1, tx 0xA5, MISO loopback -> o_mosi sequence 1,0,1,0,0,1,0,1 valid at each rise; o_rx_data=0xA5; one o_rx_valid pulse; o_cs_n low for the transfer only.
- Mode 3 (CPOL=1, CPHA=1), tx 0x3C, MISO tied 1 -> o_sclk idles 1; MOSI changes on divider rise; o_rx_data=0xFF.
- MSB_FIRST=0, mode 1, tx 0x01, loopback -> first MOSI bit 1; o_rx_data=0x01.
- Two bytes 0x12, 0x34 with i_hold_cs=1 then 0 -> o_cs_n stays 0 between bytes; rises CS_HOLD cycles after the 2nd byte; two o_rx_valid pulses.
- i_rst asserted during SHIFT at bit 4 -> next cycle o_cs_n=1, o_div_start_n=1, o_rx_valid never asserted; next transfer of 0x5A completes correctly.
- i_tx_valid held high continuously -> exactly one accept per IDLE visit; o_tx_ready=0 from accept until HOLD completes.
